// File: rtl/instr_fetch_seq_if.sv
// Fetch-side bus bundle: start control, byte-wide instruction memory port,
// decode handshake, PC redirect and status. master = fetch sequencer.
interface instr_fetch_seq_if;
    logic        start;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        done;
    logic        err;

    modport master (
        input  start, mem_rdata, instr_ready, redirect_valid, redirect_pc,
        output mem_rd_en, mem_addr, instr, instr_addr, instr_valid, done, err
    );

    modport slave (
        output start, mem_rdata, instr_ready, redirect_valid, redirect_pc,
        input  mem_rd_en, mem_addr, instr, instr_addr, instr_valid, done, err
    );
endinterface

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: reads four bytes per instruction, assembles a
// big-endian word, hands it to decode, and handles PC redirects and end of memory.
module instr_fetch_seq #(
    parameter int unsigned MEM_SIZE = 128,
    parameter logic [31:0] RESET_PC = '0
) (
    input logic             clk,
    input logic             rst_n,
    instr_fetch_seq_if.master bus
);
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [2:0]  cnt;
    logic [23:0] shift_buf;

    logic        redirect_ok;
    logic        redirect_bad;
    logic        handshake;
    logic [31:0] pc_next4;

    always_comb begin
        redirect_ok  = bus.redirect_valid && (bus.redirect_pc[1:0] == 2'b00)
                       && (bus.redirect_pc < MEM_LIMIT);
        redirect_bad = bus.redirect_valid && !redirect_ok;
        handshake    = (state == HOLD) && bus.instr_valid && bus.instr_ready;
        pc_next4     = pc + 32'd4;
        // Read strobe and address decode straight from state/pc/cnt, so the
        // first read lands in the same cycle FETCH is entered.
        bus.mem_rd_en = (state == FETCH) && (cnt != 3'd4);
        bus.mem_addr  = pc + {29'b0, cnt};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            pc              <= RESET_PC;
            cnt             <= '0;
            shift_buf       <= '0;
            bus.instr       <= '0;
            bus.instr_addr  <= '0;
            bus.instr_valid <= 1'b0;
            bus.done        <= 1'b0;
            bus.err         <= 1'b0;
        end else begin
            bus.err <= redirect_bad;
            case (state)
                IDLE: begin
                    if (redirect_ok) begin
                        pc <= bus.redirect_pc;
                    end
                    if (bus.start) begin
                        state <= FETCH;
                        cnt   <= '0;
                    end
                end
                FETCH: begin
                    if (redirect_ok) begin
                        pc  <= bus.redirect_pc;
                        cnt <= '0;
                    end else if (cnt == 3'd4) begin
                        bus.instr       <= {shift_buf, bus.mem_rdata};
                        bus.instr_addr  <= pc;
                        bus.instr_valid <= 1'b1;
                        cnt             <= '0;
                        state           <= HOLD;
                    end else begin
                        // Byte read at cnt-1 arrives now; cnt 0 has nothing yet.
                        if (cnt != 3'd0) begin
                            shift_buf <= {shift_buf[15:0], bus.mem_rdata};
                        end
                        cnt <= cnt + 3'd1;
                    end
                end
                HOLD: begin
                    // A redirect alongside a handshake consumes the instruction
                    // and overrides both pc+4 and the move to DONE.
                    if (redirect_ok) begin
                        pc              <= bus.redirect_pc;
                        cnt             <= '0;
                        bus.instr_valid <= 1'b0;
                        state           <= FETCH;
                    end else if (handshake) begin
                        pc              <= pc_next4;
                        cnt             <= '0;
                        bus.instr_valid <= 1'b0;
                        if (pc_next4 == MEM_LIMIT) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    if (redirect_ok) begin
                        pc       <= bus.redirect_pc;
                        cnt      <= '0;
                        bus.done <= 1'b0;
                        state    <= FETCH;
                    end else if (bus.start) begin
                        pc       <= RESET_PC;
                        cnt      <= '0;
                        bus.done <= 1'b0;
                        state    <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq: redirect table, directed corner
// sequences, and a randomized run against a transaction-level PC model.
module tb_instr_fetch_seq;
    localparam int unsigned MSZ = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_seq_if bus ();

    instr_fetch_seq #(.MEM_SIZE(MSZ), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] mem [MSZ];
    int oob_reads = 0;

    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            if (bus.mem_addr >= 32'(MSZ)) oob_reads++;
            else bus.mem_rdata <= mem[bus.mem_addr[6:0]];
        end
    end

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [6:0] b;
        b = a[6:0];
        return {mem[b], mem[b + 7'd1], mem[b + 7'd2], mem[b + 7'd3]};
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.instr_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_valid(input int limit, input string name);
        int n = 0;
        while (!bus.instr_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'b0, bus.instr_valid}, 32'd1);
    endtask

    typedef struct {
        logic [31:0] rpc;
        logic        exp_err;
        logic [31:0] exp_addr;
    } redir_vec_t;

    redir_vec_t tbl [8];

    initial begin
        int hs_cnt, hs_cycle, done_cycle, n;
        logic [31:0] last_addr, held_instr;
        logic [31:0] exp_pc, tgt;
        logic exp_err, exp_done, exp_kill, ok, hs, rv;

        tbl[0] = '{32'h40, 1'b0, 32'h40};
        tbl[1] = '{32'h42, 1'b1, 32'h40};
        tbl[2] = '{32'h80, 1'b1, 32'h40};
        tbl[3] = '{32'h7C, 1'b0, 32'h7C};
        tbl[4] = '{32'hFFFF_FFFC, 1'b1, 32'h7C};
        tbl[5] = '{32'h03, 1'b1, 32'h7C};
        tbl[6] = '{32'h7F, 1'b1, 32'h7C};
        tbl[7] = '{32'h00, 1'b0, 32'h00};

        for (int i = 0; i < int'(MSZ); i++) mem[i] = 8'($urandom);
        mem[0] = 8'h10; mem[1] = 8'h4A; mem[2] = 8'h60; mem[3] = 8'h0B;
        bus.mem_rdata = '0;

        // Reset values while held in reset
        bus.start = 1'b0; bus.instr_ready = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
        @(negedge clk);
        check("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
        check("rst_rd_en", {31'b0, bus.mem_rd_en}, 32'd0);
        check("rst_addr", bus.mem_addr, 32'h0);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_iaddr", bus.instr_addr, 32'h0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_err", {31'b0, bus.err}, 32'd0);
        apply_reset();

        // Redirect table in IDLE: mem_addr tracks pc there
        for (int i = 0; i < 8; i++) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc = tbl[i].rpc;
            @(negedge clk);
            bus.redirect_valid = 1'b0;
            check("tbl_err", {31'b0, bus.err}, {31'b0, tbl[i].exp_err});
            check("tbl_pc", bus.mem_addr, tbl[i].exp_addr);
            check("tbl_rd_en", {31'b0, bus.mem_rd_en}, 32'd0);
            @(negedge clk);
            check("tbl_err_clr", {31'b0, bus.err}, 32'd0);
        end

        // Start: reads 0..3, instruction 6 cycles after start
        apply_reset();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("start_rd_en", {31'b0, bus.mem_rd_en}, 32'd1);
            check("start_addr", bus.mem_addr, 32'(k));
            @(negedge clk);
        end
        check("start_idle_rd", {31'b0, bus.mem_rd_en}, 32'd0);
        check("start_early_valid", {31'b0, bus.instr_valid}, 32'd0);
        @(negedge clk);
        check("start_valid", {31'b0, bus.instr_valid}, 32'd1);
        check("start_instr", bus.instr, 32'h104A600B);
        check("start_iaddr", bus.instr_addr, 32'h0);

        // Backpressure in HOLD
        held_instr = bus.instr;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_valid", {31'b0, bus.instr_valid}, 32'd1);
            check("bp_instr", bus.instr, held_instr);
            check("bp_rd_en", {31'b0, bus.mem_rd_en}, 32'd0);
        end
        bus.instr_ready = 1'b1;
        @(negedge clk);
        check("bp_next_rd", {31'b0, bus.mem_rd_en}, 32'd1);
        check("bp_next_addr", bus.mem_addr, 32'h4);
        check("bp_valid_drop", {31'b0, bus.instr_valid}, 32'd0);

        // Redirect mid-fetch at pc=8, cnt=2
        n = 0;
        while (!(bus.mem_rd_en && bus.mem_addr == 32'hA) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("mid_reach", {31'b0, bus.mem_rd_en}, 32'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h40;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        check("mid_valid", {31'b0, bus.instr_valid}, 32'd0);
        check("mid_rd_en", {31'b0, bus.mem_rd_en}, 32'd1);
        check("mid_addr", bus.mem_addr, 32'h40);
        wait_valid(20, "mid_wait");
        bus.instr_ready = 1'b0;
        check("mid_iaddr", bus.instr_addr, 32'h40);
        check("mid_instr", bus.instr, word_at(32'h40));

        // Bad redirects while held in HOLD
        for (int k = 0; k < 2; k++) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc = (k == 0) ? 32'h42 : 32'h80;
            @(negedge clk);
            bus.redirect_valid = 1'b0;
            check("bad_err", {31'b0, bus.err}, 32'd1);
            check("bad_valid", {31'b0, bus.instr_valid}, 32'd1);
            check("bad_iaddr", bus.instr_addr, 32'h40);
            check("bad_rd_en", {31'b0, bus.mem_rd_en}, 32'd0);
            @(negedge clk);
            check("bad_err_pulse", {31'b0, bus.err}, 32'd0);
        end
        bus.instr_ready = 1'b1;
        @(negedge clk);
        check("bad_next_addr", bus.mem_addr, 32'h44);
        bus.instr_ready = 1'b0;

        // End of memory: 32 handshakes then DONE
        apply_reset();
        bus.start = 1'b1;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        hs_cnt = 0; hs_cycle = -10; done_cycle = -1; last_addr = '1;
        for (int c = 0; c < 400 && !bus.done; c++) begin
            if (bus.instr_valid) begin
                check("eom_seq", bus.instr_addr, 32'(hs_cnt * 4));
                last_addr = bus.instr_addr;
                hs_cnt++;
                hs_cycle = c;
            end
            @(negedge clk);
            if (bus.done) done_cycle = c + 1;
        end
        check("eom_count", 32'(hs_cnt), 32'd32);
        check("eom_last", last_addr, 32'h7C);
        check("eom_done", {31'b0, bus.done}, 32'd1);
        check("eom_done_lat", 32'(done_cycle - hs_cycle), 32'd1);
        n = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.mem_rd_en) n++;
        end
        check("eom_no_reads", 32'(n), 32'd0);
        check("eom_oob", 32'(oob_reads), 32'd0);
        #2 rst_n = 1'b0;
        #1 check("rst_done_async", {31'b0, bus.done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.instr_ready = 1'b0;
        @(negedge clk);

        // Asynchronous reset in HOLD
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h20;
        bus.start = 1'b1;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        bus.start = 1'b0;
        wait_valid(20, "ar_wait");
        check("ar_iaddr", bus.instr_addr, 32'h20);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", {31'b0, bus.instr_valid}, 32'd0);
        check("ar_done", {31'b0, bus.done}, 32'd0);
        check("ar_instr", bus.instr, 32'h0);
        check("ar_pc", bus.mem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.mem_rd_en || bus.done || bus.instr_valid) n++;
        end
        check("ar_idle", 32'(n), 32'd0);

        // Randomized run against a transaction-level model
        apply_reset();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        exp_pc = 32'h0; exp_err = 1'b0; exp_done = 1'b0; exp_kill = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            check("rnd_err", {31'b0, bus.err}, {31'b0, exp_err});
            check("rnd_done", {31'b0, bus.done}, {31'b0, exp_done});
            if (exp_kill) check("rnd_kill", {31'b0, bus.instr_valid}, 32'd0);

            bus.instr_ready = ($urandom_range(0, 3) != 0);
            rv = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 3))
                0, 1: tgt = {25'b0, 5'($urandom_range(0, 31)), 2'b00};
                2: tgt = 32'($urandom_range(0, 127)) | 32'h1;
                default: tgt = 32'(MSZ) + 32'($urandom_range(0, 1000));
            endcase
            bus.redirect_valid = rv;
            bus.redirect_pc = tgt;
            bus.start = exp_done && ($urandom_range(0, 3) == 0);

            hs = bus.instr_valid && bus.instr_ready;
            if (hs) begin
                check("rnd_iaddr", bus.instr_addr, exp_pc);
                check("rnd_instr", bus.instr, word_at(exp_pc));
            end
            ok = rv && (tgt[1:0] == 2'b00) && (tgt < 32'(MSZ));
            exp_err = rv && !ok;
            exp_kill = ok;
            if (ok) begin
                exp_pc = tgt;
                exp_done = 1'b0;
            end else if (hs) begin
                exp_pc = exp_pc + 32'd4;
                if (exp_pc == 32'(MSZ)) exp_done = 1'b1;
            end else if (exp_done && bus.start) begin
                exp_pc = 32'h0;
                exp_done = 1'b0;
            end
        end
        bus.redirect_valid = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("rnd_oob", 32'(oob_reads), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
